processor_datapath: RTL and testbench

PROCESSOR_DATAPATH -- requirements
Module: processor_datapath

---
 rtl/proc_pkg.sv | 18 +
 rtl/datapath_alu.sv | 31 +++
 rtl/processor_datapath.sv | 57 +++++
 tb/tb_processor_datapath.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: datapath widths and ALU opcodes shared with the controller
package proc_pkg;
  localparam int WIDTH = 10;
  localparam int NREGS = 4;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_INV  = 4'd2,
    ALU_FLP  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_LSL  = 4'd7,
    ALU_LSR  = 4'd8,
    ALU_ASR  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_t;
endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU on accumulator A and bus operand B
module datapath_alu #(
  parameter int WIDTH = proc_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y
);
  import proc_pkg::*;
  alu_op_t o;
  assign o = alu_op_t'(op);
  // shift operators already yield 0 (or sign fill for ASR) once b reaches WIDTH
  always_comb begin
    y = '0;
    case (o)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_INV:  y = -b;
      ALU_FLP:  y = ~b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_LSL:  y = a << b;
      ALU_LSR:  y = a >> b;
      ALU_ASR:  y = $signed(a) >>> b;
      ALU_PASS: y = b;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/processor_datapath.sv
// processor_datapath: shared bus, register file, A/G/IR registers and step counter
module processor_datapath #(
  parameter int WIDTH = proc_pkg::WIDTH,
  parameter int NREGS = proc_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Data,
  input  logic [WIDTH-1:0] IMM,
  input  logic             Ext,
  input  logic             Gout,
  input  logic             Iout,
  input  logic             ENR,
  input  logic             ENW,
  input  logic             Ain,
  input  logic             Gin,
  input  logic             IRin,
  input  logic             Clr,
  input  logic [1:0]       Rin,
  input  logic [1:0]       Rout,
  input  logic [3:0]       ALUcont,
  output logic [WIDTH-1:0] IR,
  output logic [1:0]       timestep,
  output logic [WIDTH-1:0] Bus,
  output logic             BusErr,
  output logic             Zero,
  output logic             Neg
);
  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] a, g, alu_y;
  assign Bus = Ext ? Data : Gout ? g : Iout ? IMM : ENR ? r[Rout] : '0;
  datapath_alu #(.WIDTH(WIDTH)) u_alu (.a(a), .b(Bus), .op(ALUcont), .y(alu_y));
  // all loads sample the same pre-edge bus value; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
      a        <= '0;
      g        <= '0;
      IR       <= '0;
      timestep <= '0;
      Zero     <= 1'b0;
      Neg      <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      if (ENW) r[Rin] <= Bus;
      if (Ain) a <= Bus;
      if (Gin) begin
        g    <= alu_y;
        Zero <= alu_y == '0;
        Neg  <= alu_y[WIDTH-1];
      end
      if (IRin) IR <= Data;
      timestep <= Clr ? 2'd0 : timestep + 2'd1;
      BusErr   <= BusErr | ($countones({Ext, Gout, Iout, ENR}) > 1);
    end
  end
endmodule

// File: tb/tb_processor_datapath.sv
// tb_processor_datapath: directed checks of bus, registers, ALU, counter and reset
module tb_processor_datapath;
  localparam int W = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] Data, IMM, IR, Bus;
  logic Ext, Gout, Iout, ENR, ENW, Ain, Gin, IRin, Clr, BusErr, Zero, Neg;
  logic [1:0] Rin, Rout, timestep;
  logic [3:0] ALUcont;
  int passed = 0, total = 0;

  processor_datapath #(.WIDTH(W), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .Data(Data), .IMM(IMM), .Ext(Ext), .Gout(Gout),
    .Iout(Iout), .ENR(ENR), .ENW(ENW), .Ain(Ain), .Gin(Gin), .IRin(IRin),
    .Clr(Clr), .Rin(Rin), .Rout(Rout), .ALUcont(ALUcont), .IR(IR),
    .timestep(timestep), .Bus(Bus), .BusErr(BusErr), .Zero(Zero), .Neg(Neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    Data = '0; IMM = '0; Ext = 0; Gout = 0; Iout = 0; ENR = 0; ENW = 0;
    Ain = 0; Gin = 0; IRin = 0; Clr = 0; Rin = 0; Rout = 0; ALUcont = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic read_g(input string tag, input logic [W-1:0] exp);
    Gout = 1; #1;
    chk(tag, Bus, exp);
    Gout = 0;
  endtask

  task automatic alu_imm(input logic [3:0] op, input logic [W-1:0] b);
    Iout = 1; IMM = b; Gin = 1; ALUcont = op;
    tick();
  endtask

  task automatic load_a(input logic [W-1:0] v);
    Ext = 1; Data = v; Ain = 1;
    tick();
  endtask

  initial begin
    idle();
    #2;
    chk("rst_ir", IR, 0);
    chk("rst_ts", timestep, 0);
    chk("rst_buserr", BusErr, 0);
    chk("rst_flags", {Zero, Neg}, 0);
    chk("rst_bus", Bus, 0);
    @(negedge clk); rst = 0;
    // load R2 from switches
    Data = 10'h155; Ext = 1; ENW = 1; Rin = 2; #1;
    chk("ld_bus", Bus, 10'h155);
    tick();
    chk("ld_buserr", BusErr, 0);
    ENR = 1; Rout = 2; #1;
    chk("ld_r2", Bus, 10'h155);
    idle();
    // 3FF + 1 wraps to 0
    Ext = 1; Data = 10'h3FF; ENW = 1; Rin = 1; tick();
    ENR = 1; Rout = 1; Ain = 1; tick();
    alu_imm(4'd0, 10'h001);
    chk("add_flags", {Zero, Neg}, 2'b10);
    Gout = 1; ENW = 1; Rin = 1; #1;
    chk("add_bus", Bus, 10'h000);
    tick();
    ENR = 1; Rout = 1; #1;
    chk("add_r1", Bus, 10'h000);
    idle();
    // 3FF - 1 is negative
    alu_imm(4'd1, 10'h001);
    chk("sub_flags", {Zero, Neg}, 2'b01);
    read_g("sub_g", 10'h3FE);
    // shifts with A = 200
    load_a(10'h200);
    alu_imm(4'd9, 10'd1);  read_g("asr1", 10'h300);
    alu_imm(4'd8, 10'd1);  read_g("lsr1", 10'h100);
    alu_imm(4'd9, 10'd12); read_g("asr12", 10'h3FF);
    alu_imm(4'd7, 10'd12); read_g("lsl12", 10'h000);
    chk("lsl12_zero", Zero, 1);
    alu_imm(4'd6, 10'h0FF); read_g("xor", 10'h2FF);
    alu_imm(4'd2, 10'h001); read_g("inv", 10'h3FF);
    alu_imm(4'd10, 10'h0AB); read_g("pass", 10'h0AB);
    alu_imm(4'd12, 10'h0AB); read_g("op12", 10'h000);
    // every load from one bus value; G uses A before the edge
    Ext = 1; Data = 10'h005; ENW = 1; Rin = 3; Ain = 1; Gin = 1; ALUcont = 0; IRin = 1;
    tick();
    chk("sim_ir", IR, 10'h005);
    read_g("sim_g", 10'h205);
    ENR = 1; Rout = 3; #1;
    chk("sim_r3", Bus, 10'h005);
    idle();
    alu_imm(4'd0, 10'h003); read_g("sim_a", 10'h008);
    // contention
    Ext = 1; Gout = 1; Data = 10'h012; #1;
    chk("cont_bus", Bus, 10'h012);
    chk("cont_pre", BusErr, 0);
    tick();
    chk("cont_set", BusErr, 1);
    tick();
    chk("cont_hold", BusErr, 1);
    // step counter
    Clr = 1; tick();
    chk("ts_clr", timestep, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("ts_run%0d", i), timestep, (i + 1) % 4);
    end
    tick();
    chk("ts_two", timestep, 2);
    Clr = 1; tick();
    chk("ts_clr2", timestep, 0);
    tick(); tick(); tick();
    chk("ts_three", timestep, 3);
    Clr = 1; tick();
    chk("ts_clr_wrap", timestep, 0);
    // asynchronous reset mid-cycle
    Ext = 1; Data = 10'h2AA; ENW = 1; Rin = 3; tick();
    tick();
    chk("pre_rst_ts", timestep, 2);
    chk("pre_rst_ir", IR, 10'h005);
    #2;
    IRin = 1; Data = 10'h3C3; rst = 1; #1;
    chk("arst_ts", timestep, 0);
    chk("arst_ir", IR, 0);
    chk("arst_buserr", BusErr, 0);
    ENR = 1; Rout = 3; #1;
    chk("arst_r3", Bus, 0);
    ENR = 0; Ext = 1; ENW = 1; Rin = 3;
    @(posedge clk); #1;
    chk("rst_ir_ignored", IR, 0);
    chk("rst_ts_held", timestep, 0);
    @(negedge clk); idle(); rst = 0;
    ENR = 1; Rout = 3; #1;
    chk("rst_r3_ignored", Bus, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
